phase_frequency_detector: RTL and testbench
===========================================

# phase_frequency_detector

Converts two sampled oscillator waveforms back into a control voltage, the inverse of the voltage-controlled oscillator. It sits in the PLL feedback path. It takes the reference oscillator sample and the VCO's `output_clock_real` sample and detects rising zero crossings with hysteresis. A three-state phase/frequency detector then drives a saturating charge-pump integrator. The integrator's 10-bit unsigned output feeds the VCO's `input_voltage_real` directly. A lock indicator reports when residual phase-error pulses stay narrow.

## Interface
- `HYST`, default 256: crossing hysteresis magnitude in the 17-bit signed sample domain.
- `CP_GAIN`, default 4: charge-pump step per cycle, in LSBs of the control voltage.
- `V_INIT`, default 512: control-voltage reset value.
- `LOCK_WIDTH`, default 4: maximum UP/DOWN pulse width, in cycles, counted as "narrow".
- `LOCK_COUNT`, default 8: consecutive narrow pulses required to assert lock.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state is cleared while low.
- `ref_signal_real`  in  17  reference oscillator sample, two's complement.
- `vco_signal_real`  in  17  VCO oscillator sample, two's complement.
- `control_voltage_real`  out  10  unsigned control word to the VCO.
- `up`  out  1  high while the detector is in state UP.
- `down`  out  1  high while the detector is in state DOWN.
- `lock`  out  1  loop-locked indicator.

## Operation
- **Crossing detectors** (one per input, identical):
  - Per-channel `armed` flag, set when sample <= -HYST.
  - When `armed` and sample >= +HYST: register a one-cycle edge pulse and clear `armed`.
  - Samples strictly between -HYST and +HYST change nothing.
- **PFD FSM**, states IDLE, UP, DOWN:
  - IDLE: ref edge only -> UP; vco edge only -> DOWN; both edges or neither -> IDLE.
  - UP: vco edge -> IDLE (a ref edge in the same cycle is ignored); otherwise stay in UP.
  - DOWN: ref edge -> IDLE (a vco edge in the same cycle is ignored); otherwise stay in DOWN.
  - `up` = (state == UP); `down` = (state == DOWN). They are registered and never both high.
- **Charge pump**, evaluated each cycle from the current state:
  - UP: V = min(V + CP_GAIN, 1023).
  - DOWN: V = max(V - CP_GAIN, 0).
  - IDLE: V holds.
  - Arithmetic uses 11-bit intermediates and clamps; V never wraps.
- **Pulse width and lock:**
  - An 8-bit width counter increments each cycle in UP or DOWN, saturating at 255.
  - On each exit to IDLE, the width is compared against LOCK_WIDTH.
    - Width <= LOCK_WIDTH: a 4-bit narrow-pulse counter increments, saturating.
    - Otherwise: the narrow-pulse counter clears and `lock` drops on the next edge.
  - `lock` is set when the narrow-pulse counter reaches LOCK_COUNT.
  - The width counter clears on entry to UP or DOWN.

## Timing
- **Reset values** (asynchronous, low): `control_voltage_real` = V_INIT, `up` = 0, `down` = 0, `lock` = 0, state IDLE, both `armed` flags 0, all counters 0.
- **Deassertion:** first action on the first rising `clk` after `reset` goes high.
- **Latency:**
  - Crossing sample taken at edge k -> edge pulse registered at k.
  - FSM state changes at k+1.
  - First V update at k+2.
- **Pulse length:** with a ref crossing at edge k and a vco crossing at edge k+n:
  - `up` is high for exactly n cycles.
  - V changes by n*CP_GAIN before clamping.
- **Reset mid-operation:** the pulse is abandoned, V returns to V_INIT, and the lock history is lost.
- **Re-arming:** a channel must go back below -HYST before it can produce another edge. Each arming yields at most one edge.

## Test plan
- **Reset:** hold `reset` low, with any inputs -> `control_voltage_real` = 512, `up` = `down` = `lock` = 0. Release with inputs held at 0 -> all outputs unchanged for 20 cycles.
- **Ref leads by 5 cycles:** arm both channels at -1000. Ref steps to +1000 at edge k; vco steps to +1000 at edge k+5.
  - `up` is high from k+1 through k+5.
  - `down` stays 0.
  - Final `control_voltage_real` = 532.
- **Simultaneous crossings plus saturation:**
  - Both channels cross at the same edge -> state stays IDLE and V is unchanged.
  - Drive V to 1021, then hold a 3-cycle DOWN-free UP pulse -> V = 1023, not wrapped.
  - Symmetric case: V = 2 with a DOWN pulse -> V = 0.
- **Hysteresis:** oscillate `vco_signal_real` between -100 and +100 for 50 cycles -> no `down`/`up` activity and V constant.
- **Lock:** 8 consecutive vco-lagging pulses of width 2 -> `lock` = 1 after the 8th pulse ends. Then one width-10 pulse -> `lock` = 0 one cycle after that pulse ends.
- **Reset mid-pulse:** during an UP pulse with V = 540, pull `reset` low asynchronously between clock edges -> `up` = 0 and V = 512 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phase_frequency_detector.sv
// Phase/frequency detector for the PLL feedback path.
// Rising zero crossings with hysteresis feed a three-state PFD. The PFD drives
// a saturating charge-pump integrator that produces the VCO control word, and a
// lock flag that tracks how narrow the residual phase-error pulses are.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no phase error outstanding, control voltage holds
// S_UP   | ref crossed first, waiting for vco; control voltage rises
// S_DOWN | vco crossed first, waiting for ref; control voltage falls
module phase_frequency_detector #(
  parameter int HYST       = 256,
  parameter int CP_GAIN    = 4,
  parameter int V_INIT     = 512,
  parameter int LOCK_WIDTH = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [16:0] ref_signal_real,
  input  logic signed [16:0] vco_signal_real,
  output logic        [9:0]  control_voltage_real,
  output logic               up,
  output logic               down,
  output logic               lock
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} pfd_state_t;

  localparam logic signed [16:0] HYST_POS     = 17'(HYST);
  localparam logic signed [16:0] HYST_NEG     = -HYST_POS;
  localparam logic        [10:0] CP_STEP      = 11'(CP_GAIN);
  localparam logic        [9:0]  V_RESET      = 10'(V_INIT);
  localparam logic        [7:0]  NARROW_LIMIT = 8'(LOCK_WIDTH);
  localparam logic        [3:0]  LOCK_TARGET  = 4'(LOCK_COUNT);
  localparam logic        [10:0] V_MAX        = 11'd1023;

  pfd_state_t  state;
  logic        ref_armed;
  logic        vco_armed;
  logic        ref_edge;
  logic        vco_edge;
  logic        ref_fire;
  logic        vco_fire;
  logic [7:0]  width;
  logic [7:0]  width_inc;
  logic [3:0]  narrow_cnt;
  logic [3:0]  narrow_inc;
  logic        pulse_start;
  logic        pulse_end;
  logic        pulse_narrow;
  logic [10:0] v_wide;
  logic [10:0] v_sum;

  // A crossing fires only from the armed condition, so each arming yields one edge
  assign ref_fire = ref_armed && (ref_signal_real >= HYST_POS);
  assign vco_fire = vco_armed && (vco_signal_real >= HYST_POS);

  // Hysteretic rising-crossing detectors for both channels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_armed <= 1'b0;
      vco_armed <= 1'b0;
      ref_edge  <= 1'b0;
      vco_edge  <= 1'b0;
    end else begin
      ref_edge <= ref_fire;
      vco_edge <= vco_fire;
      if (ref_signal_real <= HYST_NEG) begin
        ref_armed <= 1'b1;
      end else if (ref_fire) begin
        ref_armed <= 1'b0;
      end
      if (vco_signal_real <= HYST_NEG) begin
        vco_armed <= 1'b1;
      end else if (vco_fire) begin
        vco_armed <= 1'b0;
      end
    end
  end

  // Three-state PFD with registered up/down outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      up    <= 1'b0;
      down  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ref_edge && !vco_edge) begin
            state <= S_UP;
            up    <= 1'b1;
          end else if (vco_edge && !ref_edge) begin
            state <= S_DOWN;
            down  <= 1'b1;
          end
        end
        S_UP: begin
          if (vco_edge) begin
            state <= S_IDLE;
            up    <= 1'b0;
          end
        end
        S_DOWN: begin
          if (ref_edge) begin
            state <= S_IDLE;
            down  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          up    <= 1'b0;
          down  <= 1'b0;
        end
      endcase
    end
  end

  // 11-bit headroom lets the clamp see the overflow before it wraps
  assign v_wide = {1'b0, control_voltage_real};
  assign v_sum  = v_wide + CP_STEP;

  // Saturating charge-pump integrator driven by the current PFD state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      control_voltage_real <= V_RESET;
    end else begin
      if (state == S_UP) begin
        control_voltage_real <= (v_sum > V_MAX) ? 10'd1023 : v_sum[9:0];
      end else if (state == S_DOWN) begin
        control_voltage_real <= (v_wide < CP_STEP) ? 10'd0 : 10'(v_wide - CP_STEP);
      end
    end
  end

  // The width seen at exit includes the exit cycle itself, so it equals the pulse length
  assign pulse_start  = (state == S_IDLE) && (ref_edge ^ vco_edge);
  assign pulse_end    = ((state == S_UP) && vco_edge) || ((state == S_DOWN) && ref_edge);
  assign width_inc    = (width == 8'hFF) ? width : width + 8'd1;
  assign narrow_inc   = (narrow_cnt == 4'hF) ? narrow_cnt : narrow_cnt + 4'd1;
  assign pulse_narrow = (width_inc <= NARROW_LIMIT);

  // Pulse-width measurement and narrow-pulse lock qualification
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      width      <= 8'd0;
      narrow_cnt <= 4'd0;
      lock       <= 1'b0;
    end else begin
      if (pulse_start) begin
        width <= 8'd0;
      end else if (state != S_IDLE) begin
        width <= width_inc;
      end
      if (pulse_end) begin
        if (pulse_narrow) begin
          narrow_cnt <= narrow_inc;
          lock       <= (narrow_inc >= LOCK_TARGET);
        end else begin
          narrow_cnt <= 4'd0;
          lock       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_frequency_detector.sv
// Self-checking bench for phase_frequency_detector: directed scenarios plus a
// randomized run compared against a cycle-stepped behavioural model.
module tb_phase_frequency_detector;

  localparam int HYST       = 256;
  localparam int CP_GAIN    = 4;
  localparam int V_INIT     = 512;
  localparam int LOCK_WIDTH = 4;
  localparam int LOCK_COUNT = 8;

  logic               clk;
  logic               reset;
  logic signed [16:0] ref_s;
  logic signed [16:0] vco_s;
  logic        [9:0]  cv;
  logic               up;
  logic               down;
  logic               lock;

  int n_checks;
  int n_fail;

  // behavioural model: direction +1 ref leads, -1 vco leads, 0 none
  bit m_ref_armed, m_vco_armed, m_ref_edge, m_vco_edge, m_lock;
  int m_dir, m_v, m_len, m_narrow;

  phase_frequency_detector #(
    .HYST(HYST), .CP_GAIN(CP_GAIN), .V_INIT(V_INIT),
    .LOCK_WIDTH(LOCK_WIDTH), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .ref_signal_real      (ref_s),
    .vco_signal_real      (vco_s),
    .control_voltage_real (cv),
    .up                   (up),
    .down                 (down),
    .lock                 (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ref_armed = 0; m_vco_armed = 0; m_ref_edge = 0; m_vco_edge = 0;
    m_lock = 0; m_dir = 0; m_v = V_INIT; m_len = 0; m_narrow = 0;
  endtask

  // one clock of the model, given the samples presented at that edge
  task automatic model_step(input int r, input int v);
    if (m_dir > 0) m_v = (m_v + CP_GAIN > 1023) ? 1023 : m_v + CP_GAIN;
    else if (m_dir < 0) m_v = (m_v - CP_GAIN < 0) ? 0 : m_v - CP_GAIN;
    if (m_dir != 0) begin
      m_len++;
      if ((m_dir > 0 && m_vco_edge) || (m_dir < 0 && m_ref_edge)) begin
        if (m_len <= LOCK_WIDTH) begin
          if (m_narrow < 15) m_narrow++;
        end else begin
          m_narrow = 0;
        end
        m_lock = (m_narrow >= LOCK_COUNT);
        m_dir = 0;
      end
    end else if (m_ref_edge != m_vco_edge) begin
      m_dir = m_ref_edge ? 1 : -1;
      m_len = 0;
    end
    m_ref_edge = m_ref_armed && (r >= HYST);
    m_vco_edge = m_vco_armed && (v >= HYST);
    if (r <= -HYST) m_ref_armed = 1; else if (m_ref_edge) m_ref_armed = 0;
    if (v <= -HYST) m_vco_armed = 1; else if (m_vco_edge) m_vco_armed = 0;
  endtask

  // present samples, clock once, land on the following falling edge
  task automatic tick(input int r, input int v);
    ref_s = 17'(r);
    vco_s = 17'(v);
    @(posedge clk);
    model_step(r, v);
    @(negedge clk);
  endtask

  // arm both, leader crosses at edge k, lagger at edge k+n, then one settle edge
  task automatic drive_pulse(input bit lead_ref, input int n);
    tick(-1000, -1000);
    if (lead_ref) tick(1000, -1000); else tick(-1000, 1000);
    for (int i = 1; i < n; i++) begin
      if (lead_ref) tick(1000, -1000); else tick(-1000, 1000);
    end
    tick(1000, 1000);
    tick(1000, 1000);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      ref_s = 17'($urandom);
      vco_s = 17'($urandom);
      @(negedge clk);
      n_checks++;
      if (cv !== 10'd512 || up !== 1'b0 || down !== 1'b0 || lock !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: cv=%0d up=%b down=%b lock=%b want cv=512 up=0 down=0 lock=0", cv, up, down, lock);
      end
    end
    ref_s = '0;
    vco_s = '0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0);
      n_checks++;
      if (cv !== 10'd512 || up !== 1'b0 || down !== 1'b0 || lock !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: cv=%0d up=%b down=%b lock=%b want 512/0/0/0", i, cv, up, down, lock);
      end
    end
  endtask

  task automatic test_ref_leads();
    tick(-1000, -1000);
    tick(1000, -1000);
    n_checks++;
    if (up !== 1'b0) begin
      n_fail++;
      $display("FAIL ref_lead_k: up=%b want 0", up);
    end
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) tick(1000, -1000); else tick(1000, 1000);
      n_checks++;
      if (up !== 1'b1 || down !== 1'b0) begin
        n_fail++;
        $display("FAIL ref_lead_pulse k+%0d: up=%b down=%b want up=1 down=0", i, up, down);
      end
    end
    tick(1000, 1000);
    n_checks++;
    if (up !== 1'b0 || down !== 1'b0 || cv !== 10'd532) begin
      n_fail++;
      $display("FAIL ref_lead_end: up=%b down=%b cv=%0d want 0/0/532", up, down, cv);
    end
  endtask

  task automatic test_simultaneous();
    tick(-1000, -1000);
    for (int i = 0; i < 5; i++) begin
      tick(1000, 1000);
      n_checks++;
      if (up !== 1'b0 || down !== 1'b0 || cv !== 10'd532) begin
        n_fail++;
        $display("FAIL simultaneous cycle %0d: up=%b down=%b cv=%0d want 0/0/532", i, up, down, cv);
      end
    end
  endtask

  task automatic test_saturation();
    drive_pulse(1'b1, 130);
    n_checks++;
    if (cv !== 10'd1023) begin
      n_fail++;
      $display("FAIL sat_high: cv=%0d want 1023", cv);
    end
    drive_pulse(1'b1, 3);
    n_checks++;
    if (cv !== 10'd1023) begin
      n_fail++;
      $display("FAIL sat_high_hold: cv=%0d want 1023", cv);
    end
    drive_pulse(1'b0, 260);
    n_checks++;
    if (cv !== 10'd0) begin
      n_fail++;
      $display("FAIL sat_low: cv=%0d want 0", cv);
    end
    drive_pulse(1'b0, 3);
    n_checks++;
    if (cv !== 10'd0) begin
      n_fail++;
      $display("FAIL sat_low_hold: cv=%0d want 0", cv);
    end
  endtask

  task automatic test_hysteresis();
    tick(-1000, -1000);
    for (int i = 0; i < 50; i++) begin
      if (i % 2 == 0) tick(200, 100); else tick(-200, -100);
      n_checks++;
      if (up !== 1'b0 || down !== 1'b0 || cv !== 10'd0) begin
        n_fail++;
        $display("FAIL hysteresis cycle %0d: up=%b down=%b cv=%0d want 0/0/0", i, up, down, cv);
      end
    end
    // both channels must still be armed after staying inside the band
    tick(0, 1000);
    tick(0, 1000);
    n_checks++;
    if (down !== 1'b1 || up !== 1'b0) begin
      n_fail++;
      $display("FAIL hyst_armed_down: down=%b up=%b want 1/0", down, up);
    end
    tick(1000, 1000);
    tick(1000, 1000);
    n_checks++;
    if (down !== 1'b0 || cv !== 10'd0) begin
      n_fail++;
      $display("FAIL hyst_armed_end: down=%b cv=%0d want 0/0", down, cv);
    end
  endtask

  task automatic test_lock();
    drive_pulse(1'b1, 10);
    for (int p = 1; p <= 8; p++) begin
      drive_pulse(1'b1, 2);
      n_checks++;
      if (lock !== (p == 8 ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL lock_narrow pulse %0d: lock=%b want %b", p, lock, (p == 8));
      end
    end
    tick(-1000, -1000);
    for (int i = 0; i < 10; i++) tick(1000, -1000);
    tick(1000, 1000);
    n_checks++;
    if (lock !== 1'b1 || up !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_wide_during: lock=%b up=%b want 1/1", lock, up);
    end
    tick(1000, 1000);
    n_checks++;
    if (lock !== 1'b0 || up !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_wide_after: lock=%b up=%b want 0/0", lock, up);
    end
  endtask

  function automatic int pick_level();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: return -1000;
      1: return -HYST;
      2: return -HYST + 1;
      3: return 0;
      4: return HYST - 1;
      5: return HYST;
      6: return 1000;
      default: return int'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  task automatic test_random();
    int r, v, r_hold, v_hold;
    r = 0; v = 0; r_hold = 0; v_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (r_hold == 0) begin r = pick_level(); r_hold = int'($urandom_range(1, 6)); end
      if (v_hold == 0) begin v = pick_level(); v_hold = int'($urandom_range(1, 6)); end
      r_hold--;
      v_hold--;
      tick(r, v);
      n_checks++;
      if (up !== (m_dir > 0) || down !== (m_dir < 0)) begin
        n_fail++;
        $display("FAIL random_updown cycle %0d: up=%b down=%b want %b/%b", i, up, down, (m_dir > 0), (m_dir < 0));
      end
      n_checks++;
      if (cv !== 10'(m_v)) begin
        n_fail++;
        $display("FAIL random_cv cycle %0d: cv=%0d want %0d", i, cv, m_v);
      end
      n_checks++;
      if (lock !== m_lock) begin
        n_fail++;
        $display("FAIL random_lock cycle %0d: lock=%b want %b", i, lock, m_lock);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(-1000, -1000);
    tick(1000, -1000);
    for (int i = 0; i < 8; i++) tick(1000, -1000);
    n_checks++;
    if (up !== 1'b1 || cv !== 10'd540) begin
      n_fail++;
      $display("FAIL mid_pulse_setup: up=%b cv=%0d want 1/540", up, cv);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (up !== 1'b0 || down !== 1'b0 || cv !== 10'd512 || lock !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pulse_async: up=%b down=%b cv=%0d lock=%b want 0/0/512/0", up, down, cv, lock);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(1000, 1000);
    tick(1000, 1000);
    n_checks++;
    if (up !== 1'b0 || cv !== 10'd512) begin
      n_fail++;
      $display("FAIL mid_pulse_after: up=%b cv=%0d want 0/512", up, cv);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ref_s    = '0;
    vco_s    = '0;
    test_reset();
    test_ref_leads();
    test_simultaneous();
    test_saturation();
    test_hysteresis();
    test_lock();
    test_random();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
